// File: rtl/tos_stack_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tos_stack_pkg                                           |
// | Purpose  : Shared types for the ForthSuper T/N-cached stack: the   |
// |            op encoding seen by the core and the FSM state encoding.|
// | Ports    : none (package)                                          |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
package tos_stack_pkg;

   // Encoding 6 is deliberately unassigned and behaves as NOP.
   typedef enum logic [2:0] {
      NOP  = 3'd0,
      PUSH = 3'd1,
      POP  = 3'd2,
      REPL = 3'd3,
      SWAP = 3'd4,
      PICK = 3'd5,
      CLR  = 3'd7
   } stack_op_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REFILL = 2'd1,
      PICKRD = 2'd2
   } stk_state_e;

endpackage
`default_nettype wire

// File: rtl/tos_stack_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tos_stack_if                                            |
// | Purpose  : Core-to-stack bundle. The core (master) drives en/op/vi |
// |            and observes T, N, depth, status flags and busy.        |
// | Ports    : en, op, vi          core -> stack                       |
// |            tos, nos, depth,                                        |
// |            empty, full, busy,                                      |
// |            ovf, unf            stack -> core                       |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
interface tos_stack_if
   import tos_stack_pkg::*;
#(
   parameter int DSZ = 32,
   parameter int DW  = 7
);
   logic            en;
   stack_op_e       op;
   logic [DSZ-1:0]  vi;
   logic [DSZ-1:0]  tos;
   logic [DSZ-1:0]  nos;
   logic [DW-1:0]   depth;
   logic            empty;
   logic            full;
   logic            busy;
   logic            ovf;
   logic            unf;

   modport master (
      output en, op, vi,
      input  tos, nos, depth, empty, full, busy, ovf, unf
   );

   modport slave (
      input  en, op, vi,
      output tos, nos, depth, empty, full, busy, ovf, unf
   );
endinterface
`default_nettype wire

// File: rtl/tos_stack_ram.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tos_stack_ram                                           |
// | Purpose  : Single-port synchronous body RAM, registered read, one  |
// |            access per cycle. Coded for block-RAM inference.        |
// | Ports    : clk  clock                                              |
// |            we   write strobe (wins over re)                        |
// |            re   read strobe, q updates on the following edge       |
// |            addr word address                                       |
// |            wd   write data                                         |
// |            q    registered read data, held when re=0               |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module tos_stack_ram #(
   parameter int WORDS = 62,
   parameter int DSZ   = 32,
   parameter int AW    = 6
) (
   input  wire logic           clk,
   input  wire logic           we,
   input  wire logic           re,
   input  wire logic [AW-1:0]  addr,
   input  wire logic [DSZ-1:0] wd,
   output logic      [DSZ-1:0] q
);
   logic [DSZ-1:0] mem [0:WORDS-1];

   // No reset on the array or q: the logical stack state lives in the
   // parent, which never consumes q without first issuing a read.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wd;
      end else if (re) begin
         q <= mem[addr];
      end
   end
endmodule
`default_nettype wire

// File: rtl/tos_stack.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tos_stack                                               |
// | Purpose  : Data/return stack with T and N in registers and deeper  |
// |            items in a single-port body RAM. Tracks depth, sticky   |
// |            ovf/unf, and raises busy for ops needing a RAM read.    |
// | Ports    : clk  clock                                              |
// |            rst  asynchronous reset, active-high                    |
// |            bus  tos_stack_if.slave (en/op/vi in, T/N/status out)   |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module tos_stack
   import tos_stack_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int DSZ   = 32,
   parameter int SSZ   = $clog2(DEPTH),
   parameter int DW    = SSZ + 1
) (
   input  wire logic  clk,
   input  wire logic  rst,
   tos_stack_if.slave bus
);
   stk_state_e     state, state_nxt;
   logic [DW-1:0]  d;
   logic [DSZ-1:0] t, n;
   logic           ovf, unf;

   logic           ram_we, ram_re;
   logic [SSZ-1:0] ram_addr;
   logic [DSZ-1:0] ram_q;

   // Decoded conditions shared by the FSM, the RAM control and datapath.
   logic           accept, is_full, is_empty, ge2, ge3, pick_ok, pick_deep;
   logic [DW-1:0]  u_ext, d_m2, d_m3, pick_idx;

   assign accept    = (state == IDLE) && bus.en;
   assign u_ext     = {1'b0, bus.vi[SSZ-1:0]};
   assign is_full   = (d == DW'(DEPTH));
   assign is_empty  = (d == '0);
   assign ge2       = (d >= DW'(2));
   assign ge3       = (d >= DW'(3));
   assign pick_ok   = (u_ext < d) && !is_full;
   assign pick_deep = (u_ext >= DW'(2));
   assign d_m2      = d - DW'(2);
   assign d_m3      = d - DW'(3);
   // Item u sits at body[d-1-u] because body[0] is the bottom of stack.
   assign pick_idx  = d - DW'(1) - u_ext;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = IDLE;
      if (accept && (bus.op == POP) && ge3) begin
         state_nxt = REFILL;
      end else if (accept && (bus.op == PICK) && pick_ok && pick_deep) begin
         state_nxt = PICKRD;
      end
   end

   // ---------------- FSM: outputs (RAM control) ----------------
   // Reads and writes are scheduled in different cycles so a single
   // port suffices: a deep PICK reads in IDLE and spills N in PICKRD.
   always_comb begin
      ram_we   = 1'b0;
      ram_re   = 1'b0;
      ram_addr = d_m2[SSZ-1:0];
      case (state)
         IDLE: begin
            if (accept) begin
               case (bus.op)
                  PUSH: ram_we = !is_full && ge2;
                  POP: begin
                     ram_re   = ge3;
                     ram_addr = d_m3[SSZ-1:0];
                  end
                  PICK: begin
                     if (pick_ok && pick_deep) begin
                        ram_re   = 1'b1;
                        ram_addr = pick_idx[SSZ-1:0];
                     end else if (pick_ok) begin
                        ram_we = ge2;
                     end
                  end
                  default: ;
               endcase
            end
         end
         PICKRD:  ram_we = ge2;
         default: ;
      endcase
   end

   tos_stack_ram #(
      .WORDS (DEPTH - 2),
      .DSZ   (DSZ),
      .AW    (SSZ)
   ) u_ram (
      .clk  (clk),
      .we   (ram_we),
      .re   (ram_re),
      .addr (ram_addr),
      .wd   (n),
      .q    (ram_q)
   );

   // ---------------- T/N, depth and flags ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         t   <= '0;
         n   <= '0;
         d   <= '0;
         ovf <= 1'b0;
         unf <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.en) begin
                  case (bus.op)
                     PUSH: begin
                        if (is_full) ovf <= 1'b1;
                        else begin
                           t <= bus.vi;
                           n <= t;
                           d <= d + DW'(1);
                        end
                     end
                     POP: begin
                        if (is_empty) unf <= 1'b1;
                        else begin
                           t <= n;
                           d <= d - DW'(1);
                           // Deep pops leave N to be refilled next cycle.
                           if (!ge3) n <= '0;
                        end
                     end
                     REPL: begin
                        if (is_empty) unf <= 1'b1;
                        else          t   <= bus.vi;
                     end
                     SWAP: begin
                        if (!ge2) unf <= 1'b1;
                        else begin
                           t <= n;
                           n <= t;
                        end
                     end
                     PICK: begin
                        if (u_ext >= d) unf <= 1'b1;
                        if (is_full)    ovf <= 1'b1;
                        if (pick_ok && !pick_deep) begin
                           // u==0 duplicates T, u==1 copies N over T.
                           if (u_ext == DW'(1)) t <= n;
                           n <= t;
                           d <= d + DW'(1);
                        end
                     end
                     CLR: begin
                        t   <= '0;
                        n   <= '0;
                        d   <= '0;
                        ovf <= 1'b0;
                        unf <= 1'b0;
                     end
                     default: ;
                  endcase
               end
            end
            REFILL: n <= ram_q;
            PICKRD: begin
               t <= ram_q;
               n <= t;
               d <= d + DW'(1);
            end
            default: ;
         endcase
      end
   end

   assign bus.tos   = t;
   assign bus.nos   = n;
   assign bus.depth = d;
   assign bus.empty = is_empty;
   assign bus.full  = is_full;
   assign bus.busy  = (state != IDLE);
   assign bus.ovf   = ovf;
   assign bus.unf   = unf;
endmodule
`default_nettype wire

// File: tb/tb_tos_stack.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_tos_stack                                            |
// | Purpose  : Directed self-checking bench for tos_stack (DEPTH=16).  |
// | Ports    : none                                                    |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module tb_tos_stack;
   import tos_stack_pkg::*;

   localparam int DEPTH = 16;
   localparam int DSZ   = 32;
   localparam int DW    = $clog2(DEPTH) + 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   tos_stack_if #(.DSZ(DSZ), .DW(DW)) bus ();

   tos_stack #(.DEPTH(DEPTH), .DSZ(DSZ)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one op for exactly one clock edge, then return to NOP.
   task automatic do_op(input stack_op_e o, input logic [DSZ-1:0] v);
      bus.en = 1'b1;
      bus.op = o;
      bus.vi = v;
      tick();
      bus.en = 1'b0;
      bus.op = NOP;
      bus.vi = '0;
   endtask

   // Bounded wait for busy to drop.
   task automatic settle(input string tag);
      int k;
      k = 0;
      while (bus.busy === 1'b1 && k < 4) begin
         tick();
         k++;
      end
      chk(tag, 64'(bus.busy), 64'd0);
   endtask

   task automatic clear();
      do_op(CLR, '0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.en = 1'b0;
      bus.op = NOP;
      bus.vi = '0;
      repeat (2) @(posedge clk);
      #1;
      // Reset state
      chk("rst_tos",   64'(bus.tos),   64'd0);
      chk("rst_nos",   64'(bus.nos),   64'd0);
      chk("rst_depth", 64'(bus.depth), 64'd0);
      chk("rst_empty", 64'(bus.empty), 64'd1);
      chk("rst_busy",  64'(bus.busy),  64'd0);
      chk("rst_flags", 64'({bus.ovf, bus.unf}), 64'd0);
      rst = 1'b0;
      tick();

      // Push four, deep pop with one busy cycle
      do_op(PUSH, 32'd11);
      do_op(PUSH, 32'd22);
      do_op(PUSH, 32'd33);
      do_op(PUSH, 32'd44);
      chk("p4_tos",   64'(bus.tos),   64'd44);
      chk("p4_nos",   64'(bus.nos),   64'd33);
      chk("p4_depth", 64'(bus.depth), 64'd4);
      do_op(POP, '0);
      chk("pop_busy1",  64'(bus.busy),  64'd1);
      chk("pop_tos_b",  64'(bus.tos),   64'd33);
      tick();
      chk("pop_busy0",  64'(bus.busy),  64'd0);
      chk("pop_tos",    64'(bus.tos),   64'd33);
      chk("pop_nos",    64'(bus.nos),   64'd22);
      chk("pop_depth",  64'(bus.depth), 64'd3);

      // Fill to capacity, overflow, drain, underflow
      clear();
      for (int i = 1; i <= DEPTH; i++) do_op(PUSH, 32'(i));
      chk("fill_full",  64'(bus.full),  64'd1);
      chk("fill_tos",   64'(bus.tos),   64'd16);
      do_op(PUSH, 32'd99);
      chk("ovf_flag",   64'(bus.ovf),   64'd1);
      chk("ovf_tos",    64'(bus.tos),   64'd16);
      chk("ovf_depth",  64'(bus.depth), 64'd16);
      for (int i = 0; i < 8; i++) begin
         do_op(POP, '0);
         settle("drain_settle");
      end
      chk("half_tos",   64'(bus.tos),   64'd8);
      chk("half_nos",   64'(bus.nos),   64'd7);
      chk("half_depth", 64'(bus.depth), 64'd8);
      for (int i = 0; i < 8; i++) begin
         do_op(POP, '0);
         settle("drain_settle");
      end
      chk("drain_empty", 64'(bus.empty), 64'd1);
      chk("drain_tos",   64'(bus.tos),   64'd0);
      chk("drain_nos",   64'(bus.nos),   64'd0);
      do_op(POP, '0);
      chk("unf_flag",    64'(bus.unf),   64'd1);
      chk("unf_depth",   64'(bus.depth), 64'd0);
      chk("unf_ovf_sticky", 64'(bus.ovf), 64'd1);
      clear();
      chk("clr_flags",   64'({bus.ovf, bus.unf}), 64'd0);

      // PICK
      do_op(PUSH, 32'd5);
      do_op(PUSH, 32'd6);
      do_op(PUSH, 32'd7);
      do_op(PUSH, 32'd8);
      do_op(PICK, 32'd3);
      chk("pick3_busy",  64'(bus.busy),  64'd1);
      tick();
      chk("pick3_busy0", 64'(bus.busy),  64'd0);
      chk("pick3_tos",   64'(bus.tos),   64'd5);
      chk("pick3_nos",   64'(bus.nos),   64'd8);
      chk("pick3_depth", 64'(bus.depth), 64'd5);
      do_op(PICK, 32'd0);
      chk("pick0_tos",   64'(bus.tos),   64'd5);
      chk("pick0_nos",   64'(bus.nos),   64'd5);
      chk("pick0_depth", 64'(bus.depth), 64'd6);
      do_op(PICK, 32'd9);
      chk("pick9_unf",   64'(bus.unf),   64'd1);
      chk("pick9_tos",   64'(bus.tos),   64'd5);
      chk("pick9_depth", 64'(bus.depth), 64'd6);
      chk("pick9_busy",  64'(bus.busy),  64'd0);
      // Spilled items must come back in order
      do_op(POP, '0);
      settle("pickpop_settle");
      chk("pickpop_nos", 64'(bus.nos),   64'd8);
      do_op(POP, '0);
      settle("pickpop_settle");
      chk("pickpop2_tos", 64'(bus.tos),  64'd8);
      chk("pickpop2_nos", 64'(bus.nos),  64'd7);

      // SWAP / REPL
      clear();
      do_op(PUSH, 32'd1);
      do_op(PUSH, 32'd2);
      do_op(SWAP, '0);
      chk("swap_tos",   64'(bus.tos),   64'd1);
      chk("swap_nos",   64'(bus.nos),   64'd2);
      do_op(REPL, 32'd99);
      chk("repl_tos",   64'(bus.tos),   64'd99);
      chk("repl_depth", 64'(bus.depth), 64'd2);
      clear();
      do_op(SWAP, '0);
      chk("swap_unf",   64'(bus.unf),   64'd1);

      // Op during busy is ignored
      clear();
      do_op(PUSH, 32'd1);
      do_op(PUSH, 32'd2);
      do_op(PUSH, 32'd3);
      do_op(POP, '0);
      do_op(PUSH, 32'd77);
      chk("ign_depth",  64'(bus.depth), 64'd2);
      chk("ign_tos",    64'(bus.tos),   64'd2);
      chk("ign_nos",    64'(bus.nos),   64'd1);
      chk("ign_flags",  64'({bus.ovf, bus.unf}), 64'd0);
      chk("ign_busy",   64'(bus.busy),  64'd0);
      do_op(PUSH, 32'd77);
      chk("push77_tos", 64'(bus.tos),   64'd77);
      chk("push77_depth", 64'(bus.depth), 64'd3);

      // Async reset in PICKRD
      do_op(PICK, 32'd2);
      chk("rstpick_busy", 64'(bus.busy), 64'd1);
      rst = 1'b1;
      #1;
      chk("rstpick_depth", 64'(bus.depth), 64'd0);
      chk("rstpick_tos",   64'(bus.tos),   64'd0);
      chk("rstpick_nos",   64'(bus.nos),   64'd0);
      chk("rstpick_busy0", 64'(bus.busy),  64'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // Undefined op, then flags cleared by CLR
      for (int i = 1; i <= DEPTH; i++) do_op(PUSH, 32'(100 + i));
      do_op(PUSH, 32'd1);
      chk("ovf2_flag",  64'(bus.ovf),   64'd1);
      do_op(stack_op_e'(3'd6), 32'd55);
      chk("undef_tos",   64'(bus.tos),   64'd116);
      chk("undef_depth", 64'(bus.depth), 64'd16);
      clear();
      chk("clr2_ovf",   64'(bus.ovf),   64'd0);
      chk("clr2_unf",   64'(bus.unf),   64'd0);
      chk("clr2_depth", 64'(bus.depth), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/tos_stack.md
Name: tos_stack

Overview:
Parametrised successor to the single-port data/return stack for the ForthSuper core.
- Top-of-stack (T) and next-on-stack (N) are held in registers.
- Deeper items live in a single-port synchronous-read body RAM.
- The core sees T and N with zero latency; an extended op set is supported.
- Depth is tracked, with sticky overflow/underflow flags and a busy handshake for ops that need a RAM read.

Parameters:
DEPTH, 64, total item capacity including T and N (>=4); body RAM holds DEPTH-2 items
DSZ, 32, data width in bits
SSZ, $clog2(DEPTH), body address width
DW, SSZ+1, depth counter width (must represent 0..DEPTH)

Ports:
clk  input  1  clock, all state changes on rising edge
rst  input  1  asynchronous reset, active-high
en  input  1  op qualifier; op is accepted when en=1 and busy=0
op  input  3  stack_op_e: NOP, PUSH, POP, REPL, SWAP, PICK, CLR
vi  input  DSZ  push/replace value; for PICK, vi[SSZ-1:0] is the index u
tos  output  DSZ  T register
nos  output  DSZ  N register
depth  output  DW  item count d, 0..DEPTH
empty  output  1  d==0
full  output  1  d==DEPTH
busy  output  1  high in REFILL and PICKRD states
ovf  output  1  sticky overflow
unf  output  1  sticky underflow

Behaviour:
- Reset (async, any state): state=IDLE, d=0, tos=0, nos=0, ovf=0, unf=0, busy=0. A reset during REFILL/PICKRD aborts the op; no partial write survives into the logical state.
- Item layout: T=item0, N=item1, body[k] holds item d-1-(k+... ) ordered bottom-up; body occupancy = max(d-2,0), next free slot = d-2.
- FSM states: IDLE, REFILL, PICKRD. Ops are only accepted in IDLE. Ops presented while busy=1 are ignored, with no flag and no state change.
- PUSH: if d==DEPTH, set ovf and make no change. Otherwise T<=vi, N<=T, and if d>=2 then body[d-2]<=N; d<=d+1. Completes in 1 cycle, stays IDLE.
- POP: if d==0, set unf and make no change. Otherwise T<=N, d<=d-1.
  - If d>=3: drive the RAM read of body[d-3] in the same cycle, go to REFILL, N<=ram_q at the next edge, then return to IDLE.
  - If d<3: N<=0, stay IDLE.
  - busy is high exactly 1 cycle after a deep POP.
- REPL: d>=1 required, else set unf. T<=vi. 1 cycle.
- SWAP: d>=2 required, else set unf. T<=N, N<=T. 1 cycle.
- PICK u: requires u<d and d<DEPTH. If u>=d, set unf; if d==DEPTH, set ovf; flag only, no change. Copy of item u is pushed.
  - u==0: T<=T, N<=T, spill as PUSH. 1 cycle.
  - u==1: T<=N, N<=T, spill as PUSH. 1 cycle.
  - u>=2: cycle 0 reads body[d-1-u] and goes to PICKRD. In PICKRD: T<=ram_q, N<=T, body[d-2]<=N (if d>=2), d<=d+1, then IDLE.
  - The single-port RAM sees its read and write in different cycles.
- CLR: d<=0, T<=0, N<=0, ovf<=0, unf<=0. 1 cycle. This is the only way (besides rst) to clear the flags.
- NOP or an undefined encoding: no change.
- Outputs tos/nos/depth/empty/full are registered state. Values stale beyond d (e.g. nos when d<2) are 0 after POP/CLR/reset.
- Arithmetic: d is unsigned DW bits and never wraps; the guards above prevent it. RAM addresses are SSZ bits.

Decomposition:
- Shared package forthsuper_pkg: typedef enum logic[2:0] stack_op_e {NOP=0,PUSH=1,POP=2,REPL=3,SWAP=4,PICK=5,CLR=7}; typedef enum stk_state_e {IDLE,REFILL,PICKRD}.
- Sub-module stack_ram: single-port synchronous RAM (DEPTH-2 x DSZ, registered read, one read or write per cycle), behaviourally coded for EBR inference.
- FSM, T/N registers, depth counter and flags stay in tos_stack.

Test Plan:
- Reset then PUSH 11,22,33,44 -> tos=44, nos=33, depth=4. POP -> busy=1 for exactly 1 cycle, then tos=33, nos=22, depth=3.
- DEPTH=8: push 1..8 -> full=1. PUSH 9 -> ovf=1, tos=8, depth=8. POP x8 -> empty=1, tos=0, nos=0. POP -> unf=1, depth=0.
- Push 5,6,7,8 then PICK u=3 -> busy 1 cycle, then tos=5, nos=8, depth=5. PICK u=0 -> tos=5, nos=5, depth=6. PICK u=9 -> unf=1, no change.
- Push 1,2; SWAP -> tos=1, nos=2. REPL vi=99 -> tos=99, depth=2. From empty, SWAP -> unf=1.
- Deep POP then, in the busy cycle, present PUSH 77 -> PUSH is ignored, depth decremented by exactly 1, no flags. After busy drops, PUSH 77 -> tos=77.
- Assert rst mid-PICKRD -> immediately depth=0, tos=0, busy=0. Set ovf, then CLR -> ovf=0, unf=0, depth=0.
